// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with load-use hazard detection,
// bubble insertion on flush or stall, and a saturating stall counter.
module decode_execute_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [N-1:0] RD1_i,
  input  logic [N-1:0] RD2_i,
  input  logic [N-1:0] ExtImm_i,
  input  logic [3:0]   A1_i,
  input  logic [3:0]   A2_i,
  input  logic [3:0]   A3_i,
  input  logic         Use1_i,
  input  logic         Use2_i,
  input  logic         RegWrite_i,
  input  logic         MemtoReg_i,
  input  logic         MemWrite_i,
  input  logic         ALUSrc_i,
  input  logic [1:0]   ALUControl_i,
  input  logic [1:0]   FlagWrite_i,
  input  logic [3:0]   Cond_i,
  output logic [N-1:0] RD1_o,
  output logic [N-1:0] RD2_o,
  output logic [N-1:0] ExtImm_o,
  output logic [3:0]   A1_o,
  output logic [3:0]   A2_o,
  output logic [3:0]   A3_o,
  output logic         RegWrite_o,
  output logic         MemtoReg_o,
  output logic         MemWrite_o,
  output logic         ALUSrc_o,
  output logic [1:0]   ALUControl_o,
  output logic [1:0]   FlagWrite_o,
  output logic [3:0]   Cond_o,
  output logic         valid_o,
  output logic         stall_o,
  output logic [15:0]  stall_cnt_o
);

  typedef struct packed {
    logic         valid;
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;
    logic [N-1:0] imm;
    logic [3:0]   a1;
    logic [3:0]   a2;
    logic [3:0]   a3;
    logic         reg_write;
    logic         mem_to_reg;
    logic         mem_write;
    logic         alu_src;
    logic [1:0]   alu_ctrl;
    logic [1:0]   flag_write;
    logic [3:0]   cond;
  } de_t;

  de_t         de_d, de_q;
  logic [15:0] stall_cnt_d, stall_cnt_q;
  logic        hazard;
  logic        bubble;

  // R15 is the PC and is never produced by a load, so it never creates a hazard.
  always_comb begin
    hazard = 1'b0;
    if (de_q.a3 != 4'hF)
      hazard = (Use1_i && (A1_i == de_q.a3)) || (Use2_i && (A2_i == de_q.a3));
    stall_o = de_q.valid && de_q.reg_write && de_q.mem_to_reg && valid_i && hazard;
  end

  always_comb begin
    bubble = flush_i || stall_o || !valid_i;

    de_d            = '0;
    de_d.valid      = !bubble;
    de_d.rd1        = RD1_i;
    de_d.rd2        = RD2_i;
    de_d.imm        = ExtImm_i;
    de_d.a1         = A1_i;
    de_d.a2         = A2_i;
    de_d.a3         = A3_i;
    de_d.reg_write  = RegWrite_i && !bubble;
    de_d.mem_to_reg = MemtoReg_i;
    de_d.mem_write  = MemWrite_i && !bubble;
    de_d.alu_src    = ALUSrc_i;
    de_d.alu_ctrl   = ALUControl_i;
    de_d.flag_write = bubble ? 2'b00 : FlagWrite_i;
    de_d.cond       = Cond_i;

    // A flushed stall cycle is a single bubble and is not counted.
    stall_cnt_d = stall_cnt_q;
    if (stall_o && !flush_i && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      de_q        <= de_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign valid_o      = de_q.valid;
  assign RD1_o        = de_q.rd1;
  assign RD2_o        = de_q.rd2;
  assign ExtImm_o     = de_q.imm;
  assign A1_o         = de_q.a1;
  assign A2_o         = de_q.a2;
  assign A3_o         = de_q.a3;
  assign RegWrite_o   = de_q.reg_write;
  assign MemtoReg_o   = de_q.mem_to_reg;
  assign MemWrite_o   = de_q.mem_write;
  assign ALUSrc_o     = de_q.alu_src;
  assign ALUControl_o = de_q.alu_ctrl;
  assign FlagWrite_o  = de_q.flag_write;
  assign Cond_o       = de_q.cond;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
